peak_tracker: RTL and testbench
===============================

# peak_tracker

Parametrised extremum tracker for sampled ADC/feedback waveforms in the hybrid-control datapath. It low-pass filters the input with a power-of-two moving average and runs a hysteretic RISING/FALLING state machine, with all logic on i_clock. Per cycle of the waveform it reports the positive peak, the negative peak, the half peak-to-peak amplitude and the period in samples. It sits between the ADC front end and the resonant-converter control law, which needs the oscillation amplitude and frequency.

## Interface
- WIDTH, 32: sample width, signed two's complement.
- AVG_LOG2, 2: moving-average depth is 2^AVG_LOG2 samples. 0 bypasses averaging but keeps the 1-cycle register.
- HYST, 16: hysteresis in LSB, unsigned, must be below 2^(WIDTH-1). A reversal is declared only when the signal departs more than HYST from the running extremum.
- HOLDOFF, 0: minimum number of filtered samples after a detection before the next detection is allowed.
- PER_W, 16: period counter width.
- Reset i_RESET, asynchronous, active-low; clock i_clock.
- i_clock  in  1  clock.
- i_RESET  in  1  asynchronous active-low reset.
- i_valid  in  1  qualifies i_data for the current cycle.
- i_data  in  WIDTH  signed sample.
- o_max  out  WIDTH  signed, last captured positive peak (filtered).
- o_min  out  WIDTH  signed, last captured negative peak (filtered).
- o_amplitude  out  WIDTH  unsigned, (o_max - o_min) >> 1.
- o_period  out  PER_W  filtered samples between the last two maxima.
- o_max_strobe  out  1  one-cycle pulse when a new o_max is captured.
- o_min_strobe  out  1  one-cycle pulse when a new o_min is captured.
- o_locked  out  1  high once at least one maximum and one minimum have been captured.

## Operation
- **Filter:**
  - A shift register of 2^AVG_LOG2 samples feeds a running sum of WIDTH+AVG_LOG2 bits: add new, subtract oldest.
  - x = sum >>> AVG_LOG2 (arithmetic shift, floor).
  - History resets to 0. x is produced only for valid samples, and the xv strobe follows i_valid by one cycle.
- **States:** INIT, SEEK, RISING, FALLING. State changes happen only on xv.
- **INIT:** counts 2^AVG_LOG2 valid samples to fill the filter, then moves to SEEK. No tracking is done in INIT.
- **SEEK:**
  - The first x loads run_max = run_min = x.
  - On later samples, update run_max and run_min.
  - If x > run_min + HYST, go to RISING with run_max = x.
  - Else, if x < run_max - HYST, go to FALLING with run_min = x.
- **RISING:**
  - run_max = max(run_max, x).
  - If x < run_max - HYST and holdoff has expired: o_max <= run_max, pulse o_max_strobe, run_min <= x, go to FALLING.
- **FALLING:** mirror of RISING. Capture o_min, pulse o_min_strobe, go to RISING.
- **Comparisons:** all threshold arithmetic is done in WIDTH+1 bits, so there is no wrap at the range extremes.
- **Amplitude:** computed in WIDTH+1 bits, then shifted right by 1. It always fits in WIDTH unsigned. It updates on every strobe.
- **Period:**
  - The counter increments on each xv and saturates at 2^PER_W-1.
  - On a max detection: o_period <= count including the current sample, then the counter is cleared to 0.
  - o_period is not written on the first maximum after reset.
- **Holdoff:** the counter loads HOLDOFF on each detection and decrements on xv. A detection is allowed only when it is 0.
- **Strobes:** at most one strobe per sample. The two strobes are never high together.
- **o_locked:** set on the first max/min pair. Cleared only by reset.
- **i_valid low:** filter, state, counters and outputs hold.

## Timing
- Reset (asynchronous): all outputs are 0, state is INIT, all filter history is 0.
- Edge k: i_valid sampled. Edge k+1: x registered. Edge k+2: state, o_max/o_min/o_amplitude/o_period and the strobes update together.
- Latency from the triggering input sample to its strobe is 2 cycles.
- Strobes are high for exactly one cycle.
- Back-to-back valid samples are sustained every cycle. No backpressure.
- Reset mid-operation discards the partial extremum. Restart goes through INIT again.

## Test plan
- **Reset and hold:** apply reset, then hold i_valid=0 for 20 cycles -> every output stays 0 and no strobe fires.
- **DC input:** WIDTH=16, HYST=10, constant 100 with i_valid=1 for 200 cycles -> no strobes, o_locked=0.
- **Triangle:**
  - Settings: WIDTH=16, AVG_LOG2=2, HYST=10.
  - Stimulus: triangle from 0 to 1000 in steps of 50, period 40 samples.
  - Required: o_max=950, o_min=50, o_amplitude=450.
  - From the second maximum onward, o_period=40. Each strobe arrives 2 cycles after its trigger sample.
- **Noisy triangle:** same triangle with ±4 LSB random jitter and HYST=10 -> exactly one o_max_strobe and one o_min_strobe per period.
- **Full-scale extremes:** WIDTH=16, AVG_LOG2=0, HYST=10, square wave alternating +32767 / -32768 every 8 samples -> o_max=32767, o_min=-32768, o_amplitude=32767, no wrap-induced false strobes.
- **Valid gaps and reset mid-run:**
  - Drop i_valid for 3 cycles mid-ramp -> the state and the period count are unchanged.
  - Assert i_RESET between clock edges -> outputs read 0 immediately, and tracking restarts in INIT after release.

Source files
------------

// File: rtl/peak_tracker.sv
// peak_tracker: moving-average filter followed by a hysteretic extremum
// tracker that reports positive/negative peaks, half peak-to-peak amplitude
// and the waveform period in filtered samples.
module peak_tracker #(
    parameter int WIDTH    = 32,
    parameter int AVG_LOG2 = 2,
    parameter int HYST     = 16,
    parameter int HOLDOFF  = 0,
    parameter int PER_W    = 16
) (
    input  logic                    i_clock,
    input  logic                    i_RESET,
    input  logic                    i_valid,
    input  logic signed [WIDTH-1:0] i_data,
    output logic signed [WIDTH-1:0] o_max,
    output logic signed [WIDTH-1:0] o_min,
    output logic        [WIDTH-1:0] o_amplitude,
    output logic        [PER_W-1:0] o_period,
    output logic                    o_max_strobe,
    output logic                    o_min_strobe,
    output logic                    o_locked
);

    localparam int DEPTH  = 1 << AVG_LOG2;
    localparam int SUM_W  = WIDTH + AVG_LOG2;
    localparam int EXT_W  = WIDTH + 1;
    localparam int FILL_W = AVG_LOG2 + 1;
    localparam int HO_W   = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic signed [EXT_W-1:0] HYST_E = EXT_W'(HYST);

    typedef enum logic [1:0] {INIT, SEEK, RISING, FALLING} state_t;

    logic signed [WIDTH-1:0] hist [DEPTH];
    logic signed [SUM_W-1:0] sum;
    logic                    sum_valid;
    logic signed [WIDTH-1:0] x;
    logic                    xv;

    state_t                  state, state_n;
    logic signed [WIDTH-1:0] run_max, run_max_n;
    logic signed [WIDTH-1:0] run_min, run_min_n;
    logic                    seeded, seeded_n;
    logic [FILL_W-1:0]       fill_cnt, fill_cnt_n;
    logic [PER_W-1:0]        per_cnt, per_cnt_n, per_inc;
    logic [HO_W-1:0]         hold_cnt, hold_cnt_n;
    logic                    seen_max, seen_max_n;
    logic                    seen_min, seen_min_n;
    logic signed [WIDTH-1:0] max_n, min_n;
    logic [WIDTH-1:0]        amp_n;
    logic [PER_W-1:0]        period_n;
    logic                    max_strobe_n, min_strobe_n, locked_n;

    logic signed [EXT_W-1:0] x_e, run_max_e, run_min_e, amp_diff;
    logic                    above, below;

    // Sample history and running sum; only valid samples enter the window
    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
            sum       <= '0;
            sum_valid <= 1'b0;
        end else begin
            sum_valid <= i_valid;
            if (i_valid) begin
                hist[0] <= i_data;
                for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
                sum <= sum + SUM_W'(i_data) - SUM_W'(hist[DEPTH-1]);
            end
        end
    end

    // Registered filter output: floor average of the window, with its strobe
    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            x  <= '0;
            xv <= 1'b0;
        end else begin
            xv <= sum_valid;
            if (sum_valid) x <= WIDTH'(sum >>> AVG_LOG2);
        end
    end

    // Threshold arithmetic carries one extra bit so full-scale values never wrap
    assign x_e       = EXT_W'(x);
    assign run_max_e = EXT_W'(run_max);
    assign run_min_e = EXT_W'(run_min);
    assign above     = (x_e > run_min_e + HYST_E);
    assign below     = (x_e < run_max_e - HYST_E);
    assign per_inc   = (per_cnt == '1) ? per_cnt : per_cnt + PER_W'(1);

    // Tracker state, running extrema, counters and reported results
    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            state        <= INIT;
            run_max      <= '0;
            run_min      <= '0;
            seeded       <= 1'b0;
            fill_cnt     <= '0;
            per_cnt      <= '0;
            hold_cnt     <= '0;
            seen_max     <= 1'b0;
            seen_min     <= 1'b0;
            o_max        <= '0;
            o_min        <= '0;
            o_amplitude  <= '0;
            o_period     <= '0;
            o_max_strobe <= 1'b0;
            o_min_strobe <= 1'b0;
            o_locked     <= 1'b0;
        end else begin
            state        <= state_n;
            run_max      <= run_max_n;
            run_min      <= run_min_n;
            seeded       <= seeded_n;
            fill_cnt     <= fill_cnt_n;
            per_cnt      <= per_cnt_n;
            hold_cnt     <= hold_cnt_n;
            seen_max     <= seen_max_n;
            seen_min     <= seen_min_n;
            o_max        <= max_n;
            o_min        <= min_n;
            o_amplitude  <= amp_n;
            o_period     <= period_n;
            o_max_strobe <= max_strobe_n;
            o_min_strobe <= min_strobe_n;
            o_locked     <= locked_n;
        end
    end

    // Next-state logic: everything advances only on a filtered sample
    always_comb begin
        state_n      = state;
        run_max_n    = run_max;
        run_min_n    = run_min;
        seeded_n     = seeded;
        fill_cnt_n   = fill_cnt;
        per_cnt_n    = per_cnt;
        hold_cnt_n   = hold_cnt;
        seen_max_n   = seen_max;
        seen_min_n   = seen_min;
        max_n        = o_max;
        min_n        = o_min;
        period_n     = o_period;
        max_strobe_n = 1'b0;
        min_strobe_n = 1'b0;
        if (xv) begin
            per_cnt_n  = per_inc;
            hold_cnt_n = (hold_cnt != '0) ? hold_cnt - HO_W'(1) : '0;
            case (state)
                INIT: begin
                    fill_cnt_n = fill_cnt + FILL_W'(1);
                    if (fill_cnt == FILL_W'(DEPTH - 1)) state_n = SEEK;
                end
                SEEK: begin
                    if (!seeded) begin
                        seeded_n  = 1'b1;
                        run_max_n = x;
                        run_min_n = x;
                    end else if (above) begin
                        state_n   = RISING;
                        run_max_n = x;
                    end else if (below) begin
                        state_n   = FALLING;
                        run_min_n = x;
                    end else begin
                        if (x_e > run_max_e) run_max_n = x;
                        if (x_e < run_min_e) run_min_n = x;
                    end
                end
                RISING: begin
                    if (below && hold_cnt == '0) begin
                        max_n        = run_max;
                        max_strobe_n = 1'b1;
                        run_min_n    = x;
                        state_n      = FALLING;
                        seen_max_n   = 1'b1;
                        hold_cnt_n   = HO_W'(HOLDOFF);
                        per_cnt_n    = '0;
                        if (seen_max) period_n = per_inc;
                    end else if (x_e > run_max_e) begin
                        run_max_n = x;
                    end
                end
                FALLING: begin
                    if (above && hold_cnt == '0) begin
                        min_n        = run_min;
                        min_strobe_n = 1'b1;
                        run_max_n    = x;
                        state_n      = RISING;
                        seen_min_n   = 1'b1;
                        hold_cnt_n   = HO_W'(HOLDOFF);
                    end else if (x_e < run_min_e) begin
                        run_min_n = x;
                    end
                end
                default: state_n = INIT;
            endcase
        end
        amp_diff = EXT_W'(max_n) - EXT_W'(min_n);
        amp_n    = (max_strobe_n || min_strobe_n) ? WIDTH'($unsigned(amp_diff) >> 1) : o_amplitude;
        locked_n = o_locked || (seen_max_n && seen_min_n);
    end

endmodule

// File: tb/tb_peak_tracker.sv
// tb_peak_tracker: directed scenarios for peak_tracker with hand-computed
// expectations; one averaging instance and one unfiltered instance share stimulus.
module tb_peak_tracker;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               valid;
    logic signed [15:0] data;

    logic signed [15:0] a_max, a_min, b_max, b_min;
    logic [15:0]        a_amp, a_period, b_amp, b_period;
    logic               a_max_stb, a_min_stb, a_locked;
    logic               b_max_stb, b_min_stb, b_locked;

    int checks = 0;
    int passed = 0;

    int max_trig[$], max_val[$], max_per[$], max_amp[$], max_lock[$];
    int min_trig[$], min_val[$], min_amp[$], min_lock[$];
    int both_cnt;

    // Free-running clock, 10 time units per cycle
    always #5 clock = ~clock;

    peak_tracker #(.WIDTH(16), .AVG_LOG2(2), .HYST(10), .HOLDOFF(0), .PER_W(16)) dut_a (
        .i_clock(clock), .i_RESET(reset_n), .i_valid(valid), .i_data(data),
        .o_max(a_max), .o_min(a_min), .o_amplitude(a_amp), .o_period(a_period),
        .o_max_strobe(a_max_stb), .o_min_strobe(a_min_stb), .o_locked(a_locked)
    );

    peak_tracker #(.WIDTH(16), .AVG_LOG2(0), .HYST(10), .HOLDOFF(0), .PER_W(16)) dut_b (
        .i_clock(clock), .i_RESET(reset_n), .i_valid(valid), .i_data(data),
        .o_max(b_max), .o_min(b_min), .o_amplitude(b_amp), .o_period(b_period),
        .o_max_strobe(b_max_stb), .o_min_strobe(b_min_stb), .o_locked(b_locked)
    );

    function automatic int wave(input int kind, input int idx);
        int m;
        if (kind == 0) begin
            m = idx % 40;
            return 50 * ((m <= 20) ? m : 40 - m);
        end
        return (((idx / 8) % 2) == 0) ? 32767 : -32768;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        valid   = 1'b0;
        data    = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Drives a waveform (optionally with a valid gap and jitter) and records every
    // strobe together with the sample index that was presented three negedges earlier.
    task automatic run_wave(input int sel, input int kind, input int n_samples,
                            input int jitter, input int gap_at, input int gap_len);
        int seq[$];
        int trig, v, omax, omin, oamp, oper, olock;
        logic mx, mn;
        max_trig.delete(); max_val.delete(); max_per.delete(); max_amp.delete(); max_lock.delete();
        min_trig.delete(); min_val.delete(); min_amp.delete(); min_lock.delete();
        both_cnt = 0;
        for (int n = 0; n < n_samples; n++) begin
            if (n == gap_at) for (int g = 0; g < gap_len; g++) seq.push_back(-1);
            seq.push_back(n);
        end
        for (int g = 0; g < 3; g++) seq.push_back(-1);
        for (int c = 0; c < seq.size(); c++) begin
            @(negedge clock);
            trig = (c >= 3) ? seq[c-3] : -2;
            if (sel == 0) begin
                mx = a_max_stb; mn = a_min_stb;
                omax = int'(a_max); omin = int'(a_min); oamp = int'(a_amp);
                oper = int'(a_period); olock = int'(a_locked);
            end else begin
                mx = b_max_stb; mn = b_min_stb;
                omax = int'(b_max); omin = int'(b_min); oamp = int'(b_amp);
                oper = int'(b_period); olock = int'(b_locked);
            end
            if (mx && mn) both_cnt++;
            if (mx) begin
                max_trig.push_back(trig); max_val.push_back(omax); max_per.push_back(oper);
                max_amp.push_back(oamp); max_lock.push_back(olock);
            end
            if (mn) begin
                min_trig.push_back(trig); min_val.push_back(omin);
                min_amp.push_back(oamp); min_lock.push_back(olock);
            end
            if (seq[c] < 0) begin
                valid = 1'b0;
                data  = '0;
            end else begin
                v = wave(kind, seq[c]);
                if (jitter > 0) v = v + int'($urandom_range(2 * jitter)) - jitter;
                valid = 1'b1;
                data  = 16'(v);
            end
        end
        valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        valid   = 1'b0;
        data    = '0;
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({a_max, a_min, a_amp, a_period, a_max_stb, a_min_stb, a_locked} !== '0)
            $display("[TB] FAIL reset_a: got max=%0d min=%0d amp=%0d per=%0d locked=%0d, expected all 0",
                     a_max, a_min, a_amp, a_period, a_locked);
        else passed++;
        checks++;
        if ({b_max, b_min, b_amp, b_period, b_max_stb, b_min_stb, b_locked} !== '0)
            $display("[TB] FAIL reset_b: got max=%0d min=%0d amp=%0d per=%0d locked=%0d, expected all 0",
                     b_max, b_min, b_amp, b_period, b_locked);
        else passed++;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            checks++;
            if ({a_max, a_min, a_amp, a_period, a_max_stb, a_min_stb, a_locked,
                 b_max, b_min, b_amp, b_period, b_max_stb, b_min_stb, b_locked} !== '0)
                $display("[TB] FAIL idle_hold cycle %0d: got a_max=%0d a_min=%0d b_max=%0d b_min=%0d strobes=%b%b%b%b, expected all 0",
                         c, a_max, a_min, b_max, b_min, a_max_stb, a_min_stb, b_max_stb, b_min_stb);
            else passed++;
        end
    endtask

    task automatic test_dc();
        int strobes;
        strobes = 0;
        do_reset();
        for (int c = 0; c < 203; c++) begin
            @(negedge clock);
            if (a_max_stb || a_min_stb) strobes++;
            valid = (c < 200);
            data  = 16'sd100;
        end
        valid = 1'b0;
        checks++;
        if (strobes !== 0) $display("[TB] FAIL dc_strobes: got %0d, expected 0", strobes);
        else passed++;
        checks++;
        if (a_locked !== 1'b0) $display("[TB] FAIL dc_locked: got %0d, expected 0", a_locked);
        else passed++;
        checks++;
        if (a_max !== 16'sd0) $display("[TB] FAIL dc_max: got %0d, expected 0", a_max);
        else passed++;
    endtask

    task automatic test_triangle();
        do_reset();
        run_wave(0, 0, 160, 0, -1, 0);
        checks++;
        if (max_trig.size() !== 4) $display("[TB] FAIL tri_max_count: got %0d, expected 4", max_trig.size());
        else passed++;
        checks++;
        if (min_trig.size() !== 3) $display("[TB] FAIL tri_min_count: got %0d, expected 3", min_trig.size());
        else passed++;
        checks++;
        if (both_cnt !== 0) $display("[TB] FAIL tri_both_strobes: got %0d, expected 0", both_cnt);
        else passed++;
        foreach (max_trig[i]) begin
            checks++;
            if (max_trig[i] !== 23 + 40 * i) $display("[TB] FAIL tri_max_pos %0d: got sample %0d, expected %0d", i, max_trig[i], 23 + 40 * i);
            else passed++;
            checks++;
            if (max_val[i] !== 950) $display("[TB] FAIL tri_max_val %0d: got %0d, expected 950", i, max_val[i]);
            else passed++;
            checks++;
            if (max_per[i] !== ((i == 0) ? 0 : 40)) $display("[TB] FAIL tri_period %0d: got %0d, expected %0d", i, max_per[i], (i == 0) ? 0 : 40);
            else passed++;
            checks++;
            if (max_amp[i] !== ((i == 0) ? 475 : 450)) $display("[TB] FAIL tri_amp_at_max %0d: got %0d, expected %0d", i, max_amp[i], (i == 0) ? 475 : 450);
            else passed++;
            checks++;
            if (max_lock[i] !== ((i == 0) ? 0 : 1)) $display("[TB] FAIL tri_lock_at_max %0d: got %0d, expected %0d", i, max_lock[i], (i == 0) ? 0 : 1);
            else passed++;
        end
        foreach (min_trig[i]) begin
            checks++;
            if (min_trig[i] !== 43 + 40 * i) $display("[TB] FAIL tri_min_pos %0d: got sample %0d, expected %0d", i, min_trig[i], 43 + 40 * i);
            else passed++;
            checks++;
            if (min_val[i] !== 50) $display("[TB] FAIL tri_min_val %0d: got %0d, expected 50", i, min_val[i]);
            else passed++;
            checks++;
            if (min_amp[i] !== 450) $display("[TB] FAIL tri_amp_at_min %0d: got %0d, expected 450", i, min_amp[i]);
            else passed++;
            checks++;
            if (min_lock[i] !== 1) $display("[TB] FAIL tri_lock_at_min %0d: got %0d, expected 1", i, min_lock[i]);
            else passed++;
        end
    endtask

    task automatic test_noisy();
        logic in_win;
        do_reset();
        run_wave(0, 0, 160, 4, -1, 0);
        checks++;
        if (max_trig.size() !== 4) $display("[TB] FAIL noisy_max_count: got %0d, expected 4", max_trig.size());
        else passed++;
        checks++;
        if (min_trig.size() !== 3) $display("[TB] FAIL noisy_min_count: got %0d, expected 3", min_trig.size());
        else passed++;
        foreach (max_trig[i]) begin
            in_win = (max_trig[i] >= 22 + 40 * i) && (max_trig[i] <= 24 + 40 * i);
            checks++;
            if (in_win !== 1'b1) $display("[TB] FAIL noisy_max_pos %0d: got sample %0d, expected %0d..%0d", i, max_trig[i], 22 + 40 * i, 24 + 40 * i);
            else passed++;
        end
        foreach (min_trig[i]) begin
            in_win = (min_trig[i] >= 42 + 40 * i) && (min_trig[i] <= 44 + 40 * i);
            checks++;
            if (in_win !== 1'b1) $display("[TB] FAIL noisy_min_pos %0d: got sample %0d, expected %0d..%0d", i, min_trig[i], 42 + 40 * i, 44 + 40 * i);
            else passed++;
        end
    endtask

    task automatic test_full_scale();
        do_reset();
        run_wave(1, 1, 64, 0, -1, 0);
        checks++;
        if (max_trig.size() !== 3) $display("[TB] FAIL fs_max_count: got %0d, expected 3", max_trig.size());
        else passed++;
        checks++;
        if (min_trig.size() !== 3) $display("[TB] FAIL fs_min_count: got %0d, expected 3", min_trig.size());
        else passed++;
        checks++;
        if (both_cnt !== 0) $display("[TB] FAIL fs_both_strobes: got %0d, expected 0", both_cnt);
        else passed++;
        foreach (min_trig[i]) begin
            checks++;
            if (min_trig[i] !== 16 + 16 * i) $display("[TB] FAIL fs_min_pos %0d: got sample %0d, expected %0d", i, min_trig[i], 16 + 16 * i);
            else passed++;
            checks++;
            if (min_val[i] !== -32768) $display("[TB] FAIL fs_min_val %0d: got %0d, expected -32768", i, min_val[i]);
            else passed++;
            checks++;
            if (min_amp[i] !== ((i == 0) ? 16384 : 32767)) $display("[TB] FAIL fs_amp_at_min %0d: got %0d, expected %0d", i, min_amp[i], (i == 0) ? 16384 : 32767);
            else passed++;
        end
        foreach (max_trig[i]) begin
            checks++;
            if (max_trig[i] !== 24 + 16 * i) $display("[TB] FAIL fs_max_pos %0d: got sample %0d, expected %0d", i, max_trig[i], 24 + 16 * i);
            else passed++;
            checks++;
            if (max_val[i] !== 32767) $display("[TB] FAIL fs_max_val %0d: got %0d, expected 32767", i, max_val[i]);
            else passed++;
            checks++;
            if (max_amp[i] !== 32767) $display("[TB] FAIL fs_amp_at_max %0d: got %0d, expected 32767", i, max_amp[i]);
            else passed++;
            checks++;
            if (max_per[i] !== ((i == 0) ? 0 : 16)) $display("[TB] FAIL fs_period %0d: got %0d, expected %0d", i, max_per[i], (i == 0) ? 0 : 16);
            else passed++;
            checks++;
            if (max_lock[i] !== 1) $display("[TB] FAIL fs_lock_at_max %0d: got %0d, expected 1", i, max_lock[i]);
            else passed++;
        end
    endtask

    task automatic test_gap_and_reset();
        do_reset();
        run_wave(0, 0, 160, 0, 50, 3);
        checks++;
        if (max_trig.size() !== 4) $display("[TB] FAIL gap_max_count: got %0d, expected 4", max_trig.size());
        else passed++;
        foreach (max_trig[i]) begin
            checks++;
            if (max_trig[i] !== 23 + 40 * i) $display("[TB] FAIL gap_max_pos %0d: got sample %0d, expected %0d", i, max_trig[i], 23 + 40 * i);
            else passed++;
            checks++;
            if (max_per[i] !== ((i == 0) ? 0 : 40)) $display("[TB] FAIL gap_period %0d: got %0d, expected %0d", i, max_per[i], (i == 0) ? 0 : 40);
            else passed++;
        end
        // Reset lands between clock edges; outputs must clear without waiting for a clock
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({a_max, a_min, a_amp, a_period, a_max_stb, a_min_stb, a_locked} !== '0)
            $display("[TB] FAIL midrun_reset: got max=%0d min=%0d amp=%0d per=%0d locked=%0d, expected all 0",
                     a_max, a_min, a_amp, a_period, a_locked);
        else passed++;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        run_wave(0, 0, 30, 0, -1, 0);
        checks++;
        if (max_trig.size() !== 1) $display("[TB] FAIL restart_max_count: got %0d, expected 1", max_trig.size());
        else passed++;
        foreach (max_trig[i]) begin
            checks++;
            if (max_trig[i] !== 23) $display("[TB] FAIL restart_max_pos: got sample %0d, expected 23", max_trig[i]);
            else passed++;
            checks++;
            if (max_per[i] !== 0) $display("[TB] FAIL restart_period: got %0d, expected 0", max_per[i]);
            else passed++;
            checks++;
            if (max_lock[i] !== 0) $display("[TB] FAIL restart_locked: got %0d, expected 0", max_lock[i]);
            else passed++;
        end
    endtask

    // Scenario sequence followed by the summary line
    initial begin
        test_reset();
        test_dc();
        test_triangle();
        test_noisy();
        test_full_scale();
        test_gap_and_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
